core_sequencer: RTL and testbench

Run controller for the single-cycle core. It accepts a four-phase `req`/`done` handshake and holds the core in reset for a fixed number of cycles. It then enables execution until the program counter reaches the halt address, or until an optional watchdog expires, and freezes the core so its register file and data memory can be inspected. It counts executed instructions and sits between the bench/host and the core's `reset` and clock-enable inputs.

---
 rtl/core_seq_pkg.sv | 18 +
 rtl/core_seq_if.sv | 31 +++
 rtl/sat_counter.sv | 20 ++
 rtl/core_sequencer.sv | 115 +++++++++++
 tb/tb_core_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and default constants for the core run sequencer.
// The optional watchdog is selected with the CORE_SEQ_WATCHDOG_EN macro.
package core_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int DEF_D          = 12;
  localparam int DEF_HALT_PC    = 128;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_WDOG_LIMIT = 4000;

endpackage

// File: rtl/core_seq_if.sv
// Host/core-facing bundle of the run sequencer, plus the FSM state for debug.
interface core_seq_if #(
  parameter int D     = core_seq_pkg::DEF_D,
  parameter int CNT_W = core_seq_pkg::DEF_CNT_W
);
  import core_seq_pkg::*;

  // Four-phase handshake: host raises req and holds it; the sequencer raises
  // done when the run ends and keeps it high until req falls; a new run needs
  // req to rise again after done has been seen low.
  logic             req;
  logic [D-1:0]     prog_ctr;
  logic             core_reset;
  logic             core_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] icount;
  seq_state_t       state;

  modport master (
    output req, prog_ctr,
    input  core_reset, core_en, busy, done, timeout, icount, state
  );

  modport slave (
    input  req, prog_ctr,
    output core_reset, core_en, busy, done, timeout, icount, state
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at its all-ones value.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Run controller for the single-cycle core: reset hold, run until HALT_PC,
// freeze for inspection. Watchdog compiled in with CORE_SEQ_WATCHDOG_EN.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int D          = DEF_D,
  parameter int HALT_PC    = DEF_HALT_PC,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
  input  logic      clk,
  input  logic      reset,
  core_seq_if.slave bus
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  if (RST_CYCLES < 1) begin : g_bad_rst_cycles
    $error("core_sequencer: RST_CYCLES must be at least 1");
  end
  if ((CNT_W < 32) && (WDOG_LIMIT >= (1 << CNT_W))) begin : g_bad_wdog_limit
    $error("core_sequencer: WDOG_LIMIT must fit in CNT_W bits");
  end

  seq_state_t       state_q, state_d;
  logic [HW-1:0]    hold_q;
  logic [CNT_W-1:0] icount;
  logic             timeout_q;
  logic             halt, wdog_hit, start, hold_last;
  logic             core_reset_c, core_en_c, busy_c, done_c;

  assign halt      = (bus.prog_ctr == D'(HALT_PC));
  assign start     = (state_q == IDLE) && bus.req;
  assign hold_last = (hold_q == HW'(RST_CYCLES - 1));

`ifdef CORE_SEQ_WATCHDOG_EN
  assign wdog_hit = (state_q == RUN) && (icount == CNT_W'(WDOG_LIMIT));

  // Halt has priority: a run that reaches HALT_PC on the limit cycle is clean.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      timeout_q <= 1'b0;
    end else if ((state_q == RUN) && wdog_hit && !halt) begin
      timeout_q <= 1'b1;
    end
  end
`else
  assign wdog_hit  = 1'b0;
  assign timeout_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      hold_q <= '0;
    end else if (state_q == HOLD) begin
      hold_q <= hold_q + HW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    core_reset_c = 1'b1;
    core_en_c    = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) state_d = HOLD;
      end
      HOLD: begin
        busy_c = 1'b1;
        if (hold_last) state_d = RUN;
      end
      RUN: begin
        core_reset_c = 1'b0;
        busy_c       = 1'b1;
        // Zero-latency gate so the PC never steps past HALT_PC.
        core_en_c    = !halt && !wdog_hit;
        if (halt || wdog_hit) state_d = DONE;
      end
      DONE: begin
        core_reset_c = 1'b0;
        done_c       = 1'b1;
        if (!bus.req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_icount (
    .clk   (clk),
    .reset (reset),
    .clear (start),
    .inc   (core_en_c),
    .count (icount)
  );

  assign bus.core_reset = core_reset_c;
  assign bus.core_en    = core_en_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.timeout    = timeout_q;
  assign bus.icount     = icount;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: three configurations, handshake table, directed
// corner sequences and randomized runs against a trace-level run model.
module tb_core_sequencer;
  import core_seq_pkg::*;

`ifdef CORE_SEQ_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam int RST_A  = 2;
  localparam int WDOG_A = 128;
  localparam int RST_C  = 1;
  localparam int WDOG_C = 50;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  always #5 clk = ~clk;

  core_seq_if #(.D(12), .CNT_W(16)) bus_a ();
  core_seq_if #(.D(12), .CNT_W(16)) bus_b ();
  core_seq_if #(.D(12), .CNT_W(6))  bus_c ();

  core_sequencer #(.D(12), .HALT_PC(128), .RST_CYCLES(RST_A), .CNT_W(16), .WDOG_LIMIT(WDOG_A))
    u_a (.clk(clk), .reset(rst_a), .bus(bus_a.slave));
  core_sequencer #(.D(12), .HALT_PC(0), .RST_CYCLES(3), .CNT_W(16), .WDOG_LIMIT(50))
    u_b (.clk(clk), .reset(rst_b), .bus(bus_b.slave));
  core_sequencer #(.D(12), .HALT_PC(4000), .RST_CYCLES(RST_C), .CNT_W(6), .WDOG_LIMIT(WDOG_C))
    u_c (.clk(clk), .reset(rst_c), .bus(bus_c.slave));

  int total = 0;
  int bad   = 0;

  logic [11:0] pc_a, pc_b, pc_c;
  logic [11:0] trace_q[$];
  logic [15:0] exp_q[$];
  logic        exp_to_q[$];

  typedef struct {
    logic       req;
    logic [3:0] flags;  // core_reset, core_en, busy, done
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: the core models step their PC on the edge, then outputs settle.
  task automatic cycle();
    logic cr_a, en_a, cr_b, en_b, cr_c, en_c;
    cr_a = bus_a.core_reset; en_a = bus_a.core_en;
    cr_b = bus_b.core_reset; en_b = bus_b.core_en;
    cr_c = bus_c.core_reset; en_c = bus_c.core_en;
    @(posedge clk);
    #1;
    if (cr_a) pc_a = '0;
    else if (en_a) begin
      if (trace_q.size() != 0) pc_a = trace_q.pop_front();
      else pc_a = pc_a + 12'd1;
    end
    if (cr_b) pc_b = '0; else if (en_b) pc_b = pc_b + 12'd1;
    if (cr_c) pc_c = '0; else if (en_c) pc_c = pc_c + 12'd1;
    bus_a.prog_ctr = pc_a;
    bus_b.prog_ctr = pc_b;
    bus_c.prog_ctr = pc_c;
    #1;
  endtask

  // Pre-compute the PC path the core will follow and the run's outcome.
  task automatic build_trace(input bit straight);
    logic [11:0] p, nxt;
    int n;
    trace_q.delete();
    p = '0;
    n = 0;
    while (p != 12'd128) begin
      if (straight) nxt = p + 12'd1;
      else if (n >= 400) nxt = 12'd128;
      else if ($urandom_range(0, 7) == 0) nxt = 12'($urandom_range(0, 128));
      else nxt = p + 12'd1;
      trace_q.push_back(nxt);
      p = nxt;
      n++;
    end
    if (WDOG_ON && (n > WDOG_A)) begin
      exp_q.push_back(16'(WDOG_A));
      exp_to_q.push_back(1'b1);
    end else begin
      exp_q.push_back(16'(n));
      exp_to_q.push_back(1'b0);
    end
  endtask

  task automatic run_a(input int drop_at, input int dwell);
    int c, n_rst, k, held;
    logic [15:0] exp_n;
    logic exp_to;
    bit got;
    exp_n = exp_q.pop_front();
    exp_to = exp_to_q.pop_front();
    bus_a.req = 1'b1;
    cycle();
    check("a_start_busy", bus_a.busy, 1);
    check("a_start_icount_clear", bus_a.icount, 0);
    c = 0; n_rst = 0; got = 0;
    while (c < 3000) begin
      if (bus_a.done) begin
        got = 1;
        break;
      end
      if (bus_a.core_reset && bus_a.busy) n_rst++;
      if (c == drop_at) bus_a.req = 1'b0;
      cycle();
      c++;
    end
    check("a_done_seen", got, 1);
    check("a_hold_cycles", n_rst, RST_A);
    check("a_done_latency", c, RST_A + exp_n + 1);
    check("a_icount", bus_a.icount, exp_n);
    check("a_timeout", bus_a.timeout, exp_to);
    check("a_core_en_frozen", bus_a.core_en, 0);
    if (!exp_to) check("a_pc_frozen", pc_a, 128);
    k = 0; held = 0;
    while (bus_a.req && (k < dwell)) begin
      cycle();
      if (bus_a.done && !bus_a.busy && !bus_a.core_en) held++;
      k++;
    end
    check("a_done_held", held, k);
    bus_a.req = 1'b0;
    cycle();
    check("a_idle_done_low", bus_a.done, 0);
    check("a_idle_core_reset", {bus_a.core_reset, bus_a.busy}, 2'b10);
    check("a_idle_icount_kept", bus_a.icount, exp_n);
  endtask

  initial begin
    int c, done_cnt;
    bit got;

    tbl[0]  = '{1'b0, 4'b1000};
    tbl[1]  = '{1'b1, 4'b1010};
    tbl[2]  = '{1'b1, 4'b1010};
    tbl[3]  = '{1'b0, 4'b1010};
    tbl[4]  = '{1'b0, 4'b0010};
    tbl[5]  = '{1'b1, 4'b0001};
    tbl[6]  = '{1'b1, 4'b0001};
    tbl[7]  = '{1'b1, 4'b0001};
    tbl[8]  = '{1'b0, 4'b1000};
    tbl[9]  = '{1'b0, 4'b1000};
    tbl[10] = '{1'b1, 4'b1010};
    tbl[11] = '{1'b1, 4'b1010};
    tbl[12] = '{1'b1, 4'b1010};
    tbl[13] = '{1'b1, 4'b0010};
    tbl[14] = '{1'b1, 4'b0001};
    tbl[15] = '{1'b0, 4'b1000};

    pc_a = '0; pc_b = '0; pc_c = '0;
    bus_a.prog_ctr = '0; bus_b.prog_ctr = '0; bus_c.prog_ctr = '0;
    bus_a.req = 1'b0; bus_b.req = 1'b0; bus_c.req = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Reset state
    cycle();
    cycle();
    check("rst_a_flags", {bus_a.core_reset, bus_a.core_en, bus_a.busy, bus_a.done}, 4'b1000);
    check("rst_a_timeout", bus_a.timeout, 0);
    check("rst_a_icount", bus_a.icount, 0);
    check("rst_c_flags", {bus_c.core_reset, bus_c.core_en, bus_c.busy, bus_c.done}, 4'b1000);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    cycle();

    // Immediate halt and four-phase handshake (HALT_PC=0, RST_CYCLES=3)
    for (int i = 0; i < 16; i++) begin
      bus_b.req = tbl[i].req;
      cycle();
      check($sformatf("b_row%0d_flags", i),
            {bus_b.core_reset, bus_b.core_en, bus_b.busy, bus_b.done}, tbl[i].flags);
      check($sformatf("b_row%0d_icount", i), bus_b.icount, 0);
    end
    check("b_timeout", bus_b.timeout, 0);

    // Basic run with a straight-line program and 20 cycles of req held in DONE
    build_trace(1'b1);
    run_a(-1, 20);

    // Reset in the middle of a run, then a fresh run
    bus_c.req = 1'b1;
    cycle();
    for (int i = 0; i < RST_C + 40; i++) cycle();
    check("c_icount_mid", bus_c.icount, 40);
    rst_c = 1'b1;
    bus_c.req = 1'b0;
    cycle();
    check("c_rst_flags", {bus_c.core_reset, bus_c.core_en, bus_c.busy, bus_c.done}, 4'b1000);
    check("c_rst_icount", bus_c.icount, 0);
    check("c_rst_timeout", bus_c.timeout, 0);
    rst_c = 1'b0;
    cycle();
    cycle();
    bus_c.req = 1'b1;
    cycle();
    c = 0;
    for (int i = 0; i < RST_C + 5; i++) begin
      cycle();
      c++;
    end
    check("c_rerun_icount", bus_c.icount, 5);
    check("c_rerun_running", {bus_c.core_reset, bus_c.busy}, 2'b01);

`ifdef CORE_SEQ_WATCHDOG_EN
    got = 0;
    while (c < 300) begin
      if (bus_c.done) begin
        got = 1;
        break;
      end
      cycle();
      c++;
    end
    check("c_wdog_done", got, 1);
    check("c_wdog_latency", c, RST_C + WDOG_C + 1);
    check("c_wdog_timeout", bus_c.timeout, 1);
    check("c_wdog_icount", bus_c.icount, WDOG_C);
    check("c_wdog_core_en", bus_c.core_en, 0);
`else
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (bus_c.done) done_cnt++;
    end
    check("c_nowdog_no_done", done_cnt, 0);
    check("c_nowdog_timeout", bus_c.timeout, 0);
    check("c_icount_saturated", bus_c.icount, 63);
    check("c_nowdog_busy", bus_c.busy, 1);
`endif
    bus_c.req = 1'b0;
    rst_c = 1'b1;
    cycle();
    rst_c = 1'b0;

    // Randomized runs: branching programs, idle gaps, early req drops, DONE dwell
    for (int r = 0; r < 6; r++) begin
      int gap;
      build_trace(1'b0);
      gap = $urandom_range(0, 4);
      for (int i = 0; i < gap; i++) cycle();
      run_a(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 150)) : -1,
            $urandom_range(0, 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
